acq_sequencer: RTL and testbench
================================

# acq_sequencer

Per-pattern acquisition sequencer for single-pixel imaging. It decodes 16-bit SPI commands, waits for a pattern trigger from the projector, opens a photon-count gate of programmed length and counts photon pulses during it. It then hands the count to the SPI readout path over a valid/ready handshake, repeating for a programmed number of frames.

## Interface
- GATE_TICK, 100: clock cycles per gate-length unit (≥1).
- CNT_W, 32: photon counter / result width.
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- CMD_VALID  in  1  CMD valid this cycle (one-cycle strobe from SPI).
- CMD  in  16  command word.
- PATTERN_TRIG  in  1  projector trigger, already synchronized to CLK; rising edge is the event.
- PHOTON  in  1  synchronized single-cycle photon pulse.
- GATE  out  1  count window active.
- RESULT  out  CNT_W  photon count of last completed gate.
- RESULT_IDX  out  12  frame index of RESULT.
- RESULT_VALID  out  1  RESULT holds unconsumed data.
- RESULT_READY  in  1  consumer accepts RESULT.
- BUSY  out  1  state ≠ IDLE.
- DONE  out  1  one-cycle pulse when the frame sequence completes.
- OVERRUN  out  1  sticky: a result was dropped, or a trigger arrived during GATE.

## Operation
- Commands are decoded only on CMD_VALID:
  - 16'h0000: STOP (any state → IDLE).
  - 16'hFFFF: ARM (IDLE → ARMED).
  - 16'h1xxx: LEN = xxx.
  - 16'h2xxx: NFRAMES = xxx.
  - All other words are ignored.
- 1xxx/2xxx are accepted only in IDLE; otherwise ignored. ARM outside IDLE is ignored.
- Defaults after reset: LEN=1, NFRAMES=0 (0 = run until STOP). LEN=0 is treated as 1.
- ARM clears OVERRUN, the frame index and the frame counter. It does not clear a pending RESULT_VALID.
- States:
  - IDLE → ARMED on ARM.
  - ARMED → GATE on a trigger rising edge (TRIG=1 now, 0 previous cycle); the count is cleared.
  - GATE → ARMED when the gate expires after exactly LEN×GATE_TICK cycles. If NFRAMES≠0 and this was frame NFRAMES, the transition is GATE → IDLE with DONE pulsed.
  - Any state → IDLE on STOP. A gate cut short by STOP produces no result.
- Counting: each PHOTON in a cycle where GATE=1 adds 1. The count saturates at all-ones (no wrap).
- Result hand-off at gate end:
  - If RESULT_VALID=0, or RESULT_VALID=1 and RESULT_READY=1 in the same cycle: load RESULT/RESULT_IDX and set RESULT_VALID.
  - Otherwise drop the new result and set OVERRUN. The frame index still advances.
- RESULT_VALID clears on RESULT_VALID&RESULT_READY when no new load occurs that cycle.
- RESULT_IDX is 12 bits and wraps 4095 → 0.
- A trigger edge during GATE is ignored and sets OVERRUN. The edge detector keeps tracking, so a level still high after the gate ends does not retrigger.
- Simultaneous events:
  - STOP in the same cycle as a trigger edge: STOP wins.
  - PHOTON on the gate's last cycle is counted.
  - PHOTON on the cycle the trigger edge is seen is not counted.

## Timing
- Trigger edge seen at cycle t → GATE=1 from t+1 through t+LEN×GATE_TICK inclusive.
- GATE falls at t+LEN×GATE_TICK+1 and RESULT_VALID rises in that same cycle. The next trigger edge is accepted from that cycle.
- CMD accepted at cycle c → state/config update visible at c+1.
- DONE pulses for one cycle, coincident with the final RESULT_VALID rise; BUSY is 0 in the same cycle.
- Reset values: GATE=0, RESULT=0, RESULT_IDX=0, RESULT_VALID=0, BUSY=0, DONE=0, OVERRUN=0, state IDLE, LEN=1, NFRAMES=0, count 0, prescaler 0.
- RST mid-gate aborts immediately; no result is produced.

## Test plan
- GATE_TICK=4, write 16'h1003, 16'h2002, ARM; single trigger; 5 photons inside the gate → GATE high exactly 12 cycles; RESULT=5, IDX=0, VALID asserted.
- Same setup, READY held 1, two triggers spaced 20 cycles apart → results IDX 0 then 1, DONE pulses with the second, BUSY falls, third trigger ignored.
- READY held 0, NFRAMES=0, three gates → first result retained (IDX 0), OVERRUN=1 after the second gate; ARM clears OVERRUN.
- Trigger pulse arriving mid-gate → gate length unchanged, OVERRUN=1. Photons one cycle before and one cycle after the gate → not counted.
- CNT_W=4, 20 photons in one gate → RESULT=15 (saturated).
- STOP in the same cycle as a trigger edge, then STOP mid-gate, then RST mid-gate → never enters GATE (first case); GATE drops next cycle with no RESULT_VALID (second); all outputs return to reset values (third).

Source files
------------

// File: rtl/acq_sequencer_if.sv
// Bundle of command, trigger, photon and result-handshake signals for acq_sequencer.
// The host side is the master; the sequencer itself is the slave.
interface acq_sequencer_if #(
  parameter int unsigned CNT_W = 32
);
  logic             cmd_valid;
  logic [15:0]      cmd;
  logic             pattern_trig;
  logic             photon;
  logic             gate;
  logic [CNT_W-1:0] result;
  logic [11:0]      result_idx;
  logic             result_valid;
  logic             result_ready;
  logic             busy;
  logic             done;
  logic             overrun;

  modport master (
    output cmd_valid, cmd, pattern_trig, photon, result_ready,
    input  gate, result, result_idx, result_valid, busy, done, overrun
  );

  modport slave (
    input  cmd_valid, cmd, pattern_trig, photon, result_ready,
    output gate, result, result_idx, result_valid, busy, done, overrun
  );
endinterface

// File: rtl/acq_sequencer.sv
// Per-pattern acquisition sequencer: SPI command decode, trigger-started photon-count
// gate of LEN*GATE_TICK cycles, and a valid/ready result hand-off per frame.
module acq_sequencer #(
  parameter int unsigned GATE_TICK = 100,
  parameter int unsigned CNT_W     = 32
) (
  input  logic           clk_i,
  input  logic           rst_i,
  acq_sequencer_if.slave bus
);
  localparam int unsigned       TICK_W    = (GATE_TICK > 1) ? $clog2(GATE_TICK) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(GATE_TICK - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_GATE} state_e;

  state_e            state_q;
  logic [11:0]       len_q;
  logic [11:0]       nframes_q;
  logic [11:0]       unit_q;
  logic [11:0]       frame_idx_q;
  logic [11:0]       result_idx_q;
  logic [TICK_W-1:0] tick_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  result_q;
  logic              trig_q;
  logic              gate_q;
  logic              busy_q;
  logic              done_q;
  logic              result_valid_q;
  logic              overrun_q;

  logic              cmd_stop;
  logic              cmd_arm;
  logic              cmd_len;
  logic              cmd_nframes;
  logic              trig_edge;
  logic              gate_end;
  logic              last_frame;
  logic              accept;
  logic [11:0]       len_eff;
  logic [CNT_W-1:0]  count_d;

  assign cmd_stop    = bus.cmd_valid && (bus.cmd == 16'h0000);
  assign cmd_arm     = bus.cmd_valid && (bus.cmd == 16'hFFFF);
  assign cmd_len     = bus.cmd_valid && (bus.cmd[15:12] == 4'h1);
  assign cmd_nframes = bus.cmd_valid && (bus.cmd[15:12] == 4'h2);
  assign trig_edge   = bus.pattern_trig && !trig_q;

  // A programmed length of zero behaves as a single unit.
  assign len_eff    = (len_q == 12'd0) ? 12'd1 : len_q;
  assign gate_end   = (tick_q == TICK_LAST) && (unit_q == len_eff - 12'd1);
  assign last_frame = (nframes_q != 12'd0) && (frame_idx_q == nframes_q - 12'd1);
  assign accept     = !result_valid_q || bus.result_ready;
  assign count_d    = (bus.photon && (count_q != '1)) ? count_q + CNT_W'(1) : count_q;

  // NOTE: every register here uses non-blocking assignments; a later assignment in the
  // same cycle deliberately overrides an earlier default (e.g. a result load beats a consume).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= S_IDLE;
      len_q          <= 12'd1;
      nframes_q      <= 12'd0;
      unit_q         <= 12'd0;
      frame_idx_q    <= 12'd0;
      result_idx_q   <= 12'd0;
      tick_q         <= '0;
      count_q        <= '0;
      result_q       <= '0;
      trig_q         <= 1'b0;
      gate_q         <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      result_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      trig_q <= bus.pattern_trig;
      done_q <= 1'b0;
      if (result_valid_q && bus.result_ready) begin
        result_valid_q <= 1'b0;
      end

      if (cmd_stop) begin
        state_q <= S_IDLE;
        gate_q  <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (cmd_arm) begin
              state_q     <= S_ARMED;
              busy_q      <= 1'b1;
              overrun_q   <= 1'b0;
              frame_idx_q <= 12'd0;
            end else if (cmd_len) begin
              len_q <= bus.cmd[11:0];
            end else if (cmd_nframes) begin
              nframes_q <= bus.cmd[11:0];
            end
          end

          S_ARMED: begin
            if (trig_edge) begin
              state_q <= S_GATE;
              gate_q  <= 1'b1;
              count_q <= '0;
              tick_q  <= '0;
              unit_q  <= 12'd0;
            end
          end

          S_GATE: begin
            count_q <= count_d;
            if (trig_edge) begin
              overrun_q <= 1'b1;
            end
            if (tick_q == TICK_LAST) begin
              tick_q <= '0;
              unit_q <= unit_q + 12'd1;
            end else begin
              tick_q <= tick_q + TICK_W'(1);
            end

            if (gate_end) begin
              gate_q      <= 1'b0;
              frame_idx_q <= frame_idx_q + 12'd1;
              if (accept) begin
                result_q       <= count_d;
                result_idx_q   <= frame_idx_q;
                result_valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
              if (last_frame) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q <= S_ARMED;
              end
            end
          end

          default: begin
            state_q <= S_IDLE;
            gate_q  <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.gate         = gate_q;
  assign bus.result       = result_q;
  assign bus.result_idx   = result_idx_q;
  assign bus.result_valid = result_valid_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.overrun      = overrun_q;
endmodule

// File: tb/tb_acq_sequencer.sv
// Directed and randomized checks of acq_sequencer (GATE_TICK=4, CNT_W=4) against a
// frame-level reference model: gate length, photon totals, hand-off and overrun rules.
module tb_acq_sequencer;
  localparam int unsigned GT  = 4;
  localparam int unsigned CW  = 4;
  localparam int          SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  acq_sequencer_if #(.CNT_W(CW)) bus ();

  acq_sequencer #(.GATE_TICK(GT), .CNT_W(CW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [15:0] w);
    bus.cmd_valid = 1'b1;
    bus.cmd       = w;
    step();
    bus.cmd_valid = 1'b0;
    bus.cmd       = 16'h0000;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gate"},    32'(bus.gate),         32'd0);
    check({tag, "_result"},  32'(bus.result),       32'd0);
    check({tag, "_idx"},     32'(bus.result_idx),   32'd0);
    check({tag, "_valid"},   32'(bus.result_valid), 32'd0);
    check({tag, "_busy"},    32'(bus.busy),         32'd0);
    check({tag, "_done"},    32'(bus.done),         32'd0);
    check({tag, "_overrun"}, 32'(bus.overrun),      32'd0);
  endtask

  // Raise the trigger (photon 'pre' in that same slot), then drive mask[i] as the photon in
  // each of the units*GT gate slots. Returns to the slot right after the gate closes,
  // with photon = post. If mid_trig >= 0, the trigger rises in that slot and stays high.
  task automatic run_gate(input int units, input logic [63:0] mask, input bit pre,
                          input bit post, input int mid_trig,
                          output int counted, output int gcyc);
    int lt;
    lt      = units * GT;
    counted = 0;
    gcyc    = 0;
    bus.pattern_trig = 1'b1;
    bus.photon       = pre;
    step();
    bus.pattern_trig = 1'b0;
    for (int i = 0; i < lt; i++) begin
      if (bus.gate) gcyc++;
      if (i == mid_trig) bus.pattern_trig = 1'b1;
      bus.photon = mask[i];
      if (mask[i]) counted++;
      step();
    end
    bus.photon = post;
  endtask

  function automatic int sat(input int n);
    return (n > SAT) ? SAT : n;
  endfunction

  initial begin
    int          cnt, gc, len, nf, units, ngates, gap, m_res, m_idx, k;
    bit          r, m_valid, m_ovr, exp_done;
    logic [63:0] mask;

    bus.cmd_valid    = 1'b0;
    bus.cmd          = 16'h0000;
    bus.pattern_trig = 1'b0;
    bus.photon       = 1'b0;
    bus.result_ready = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    check_reset_outputs("reset");

    // Single gate: LEN=3, NFRAMES=2, five photons in the gate, one before and one after.
    send_cmd(16'h1003);
    send_cmd(16'h2002);
    send_cmd(16'hFFFF);
    check("busy_armed", 32'(bus.busy), 32'd1);
    mask = '0;
    mask[0] = 1'b1; mask[3] = 1'b1; mask[6] = 1'b1; mask[9] = 1'b1; mask[11] = 1'b1;
    run_gate(3, mask, 1'b1, 1'b1, -1, cnt, gc);
    check("g1_len",    32'(gc),               32'd12);
    check("g1_fall",   32'(bus.gate),         32'd0);
    check("g1_result", 32'(bus.result),       32'(sat(cnt)));
    check("g1_idx",    32'(bus.result_idx),   32'd0);
    check("g1_valid",  32'(bus.result_valid), 32'd1);
    check("g1_done",   32'(bus.done),         32'd0);
    check("g1_busy",   32'(bus.busy),         32'd1);
    step();
    bus.photon = 1'b0;

    // Second frame with READY held: completes the sequence.
    bus.result_ready = 1'b1;
    repeat (6) step();
    check("g1_consumed", 32'(bus.result_valid), 32'd0);
    mask = '0;
    mask[2] = 1'b1; mask[4] = 1'b1; mask[7] = 1'b1;
    run_gate(3, mask, 1'b0, 1'b0, -1, cnt, gc);
    check("g2_result", 32'(bus.result),       32'd3);
    check("g2_idx",    32'(bus.result_idx),   32'd1);
    check("g2_valid",  32'(bus.result_valid), 32'd1);
    check("g2_done",   32'(bus.done),         32'd1);
    check("g2_busy",   32'(bus.busy),         32'd0);
    step();
    check("done_pulse", 32'(bus.done), 32'd0);
    bus.pattern_trig = 1'b1;
    step();
    bus.pattern_trig = 1'b0;
    repeat (3) step();
    check("no_third_gate", 32'(bus.gate), 32'd0);

    // READY low, free-running: first result kept, later ones dropped with OVERRUN.
    bus.result_ready = 1'b0;
    send_cmd(16'h2000);
    send_cmd(16'hFFFF);
    mask = 64'h7 << 1;
    run_gate(3, mask, 1'b0, 1'b0, -1, cnt, gc);
    check("ov1_result",  32'(bus.result),  32'd3);
    check("ov1_overrun", 32'(bus.overrun), 32'd0);
    repeat (2) step();
    run_gate(3, 64'h1, 1'b0, 1'b0, -1, cnt, gc);
    check("ov2_result",  32'(bus.result),       32'd3);
    check("ov2_idx",     32'(bus.result_idx),   32'd0);
    check("ov2_overrun", 32'(bus.overrun),      32'd1);
    check("ov2_valid",   32'(bus.result_valid), 32'd1);
    repeat (2) step();
    run_gate(3, 64'h3, 1'b0, 1'b0, -1, cnt, gc);
    check("ov3_idx", 32'(bus.result_idx), 32'd0);
    send_cmd(16'h0000);
    send_cmd(16'hFFFF);
    check("arm_clr_overrun", 32'(bus.overrun),      32'd0);
    check("arm_keeps_valid", 32'(bus.result_valid), 32'd1);

    // Trigger arriving mid-gate and held high past the gate end.
    bus.result_ready = 1'b1;
    step();
    mask = '0;
    mask[0] = 1'b1; mask[11] = 1'b1;
    run_gate(3, mask, 1'b1, 1'b1, 5, cnt, gc);
    check("mid_len",     32'(gc),               32'd12);
    check("mid_overrun", 32'(bus.overrun),      32'd1);
    check("mid_result",  32'(bus.result),       32'd2);
    check("mid_idx",     32'(bus.result_idx),   32'd0);
    check("mid_valid",   32'(bus.result_valid), 32'd1);
    repeat (4) step();
    check("no_retrigger", 32'(bus.gate), 32'd0);
    bus.pattern_trig = 1'b0;
    bus.photon       = 1'b0;

    // Saturation: 20 photons into a 4-bit counter.
    send_cmd(16'h0000);
    send_cmd(16'h1005);
    send_cmd(16'hFFFF);
    run_gate(5, 64'hFFFFF, 1'b0, 1'b0, -1, cnt, gc);
    check("sat_len",    32'(gc),         32'd20);
    check("sat_result", 32'(bus.result), 32'(sat(cnt)));

    // STOP coincident with a trigger edge.
    send_cmd(16'h0000);
    send_cmd(16'h1003);
    send_cmd(16'hFFFF);
    bus.cmd_valid    = 1'b1;
    bus.cmd          = 16'h0000;
    bus.pattern_trig = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    check("stoptrig_gate", 32'(bus.gate), 32'd0);
    check("stoptrig_busy", 32'(bus.busy), 32'd0);
    step();
    check("stoptrig_gate2", 32'(bus.gate), 32'd0);
    bus.pattern_trig = 1'b0;
    check("pre_stop_valid", 32'(bus.result_valid), 32'd0);

    // STOP mid-gate: gate drops next cycle, no result.
    send_cmd(16'hFFFF);
    bus.pattern_trig = 1'b1;
    step();
    bus.pattern_trig = 1'b0;
    repeat (3) step();
    check("stopmid_open", 32'(bus.gate), 32'd1);
    send_cmd(16'h0000);
    check("stopmid_gate", 32'(bus.gate), 32'd0);
    check("stopmid_busy", 32'(bus.busy), 32'd0);
    repeat (15) step();
    check("stopmid_valid", 32'(bus.result_valid), 32'd0);

    // Reset mid-gate with a pending result and OVERRUN set.
    bus.result_ready = 1'b0;
    send_cmd(16'hFFFF);
    run_gate(3, 64'h7, 1'b0, 1'b0, 2, cnt, gc);
    check("prerst_result",  32'(bus.result),  32'd3);
    check("prerst_overrun", 32'(bus.overrun), 32'd1);
    bus.pattern_trig = 1'b0;
    step();
    bus.pattern_trig = 1'b1;
    step();
    bus.pattern_trig = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_outputs("rstmid");
    send_cmd(16'hFFFF);
    run_gate(1, 64'h1, 1'b0, 1'b0, -1, cnt, gc);
    check("deflen_len",    32'(gc),         32'(GT));
    check("deflen_result", 32'(bus.result), 32'd1);

    // Randomized frames against the frame-level model.
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_valid = 1'b0;
    m_res   = 0;
    m_idx   = 0;
    for (int it = 0; it < 8; it++) begin
      len    = $urandom_range(0, 4);
      nf     = $urandom_range(0, 3);
      r      = 1'($urandom_range(0, 1));
      units  = (len == 0) ? 1 : len;
      ngates = (nf == 0) ? 3 : nf;
      bus.result_ready = r;
      send_cmd(16'h0000);
      send_cmd(16'h1000 | 16'(len));
      send_cmd(16'h2000 | 16'(nf));
      send_cmd(16'hFFFF);
      m_ovr = 1'b0;
      k     = 0;
      for (int g = 0; g < ngates; g++) begin
        gap = $urandom_range(1, 5);
        for (int s = 0; s < gap; s++) begin
          bus.photon = 1'($urandom_range(0, 1));
          step();
        end
        if (r) m_valid = 1'b0;
        run_gate(units, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b0, -1, cnt, gc);
        if (!m_valid || r) begin
          m_valid = 1'b1;
          m_res   = sat(cnt);
          m_idx   = k;
        end else begin
          m_ovr = 1'b1;
        end
        k++;
        exp_done = (nf != 0) && (k == nf);
        check("rnd_len",     32'(gc),               32'(units * GT));
        check("rnd_fall",    32'(bus.gate),         32'd0);
        check("rnd_valid",   32'(bus.result_valid), 32'(m_valid));
        check("rnd_result",  32'(bus.result),       32'(m_res));
        check("rnd_idx",     32'(bus.result_idx),   32'(m_idx));
        check("rnd_overrun", 32'(bus.overrun),      32'(m_ovr));
        check("rnd_done",    32'(bus.done),         32'(exp_done));
        check("rnd_busy",    32'(bus.busy),         32'(!exp_done));
      end
      step();
      if (r) m_valid = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
